// File: rtl/wb_stage_gen.sv
// Writeback stage for the 5-stage MIPS pipeline.
// Holds one instruction from MEM and retires it into the register file.
// Exceptions and ERET redirect the front end from here.
// After each redirect, a fixed drain window squashes incoming MEM traffic.
module wb_stage_gen #(
  parameter int          DATA_W    = 32,
  parameter int          RF_AW     = 5,
  parameter int          EXC_W     = 8,
  parameter int          EXC_IDX_W = 3,
  parameter logic [31:0] EXC_VEC   = 32'hbfc00380,
  parameter int          DRAIN_CYC = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   ms_to_ws_valid,
  output logic                   ws_allowin,
  input  logic [31:0]            ms_pc,
  input  logic [RF_AW-1:0]       ms_dest,
  input  logic [DATA_W/8-1:0]    ms_wen,
  input  logic [DATA_W-1:0]      ms_result,
  input  logic [EXC_W-1:0]       ms_exc,
  input  logic                   ms_eret,
  input  logic                   ms_flushed,
  input  logic [31:0]            cp0_epc,
  input  logic                   rf_busy,
  output logic [DATA_W/8-1:0]    rf_we,
  output logic [RF_AW-1:0]       rf_waddr,
  output logic [DATA_W-1:0]      rf_wdata,
  output logic                   exc_flush,
  output logic                   exc_valid,
  output logic [EXC_IDX_W-1:0]   exc_idx,
  output logic [31:0]            flush_pc,
  output logic [31:0]            retire_cnt,
  output logic [31:0]            debug_wb_pc,
  output logic [DATA_W/8-1:0]    debug_wb_rf_wen,
  output logic [RF_AW-1:0]       debug_wb_rf_wnum,
  output logic [DATA_W-1:0]      debug_wb_rf_wdata
);

  localparam int BW    = DATA_W / 8;
  localparam int CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYC - 1);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  // Lowest set flag wins (bit 0 is the highest-priority source); 0 when none is set.
  function automatic logic [EXC_IDX_W-1:0] first_exc(input logic [EXC_W-1:0] flags);
    logic [EXC_IDX_W-1:0] idx;
    idx = {EXC_IDX_W{1'b0}};
    for (int i = EXC_W - 1; i >= 0; i--) begin
      if (flags[i]) begin
        idx = EXC_IDX_W'(i);
      end
    end
    return idx;
  endfunction

  // Registered state and payload.
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ws_valid_q;
  logic [31:0]         pc_q;
  logic [RF_AW-1:0]    dest_q;
  logic [BW-1:0]       wen_q;
  logic [DATA_W-1:0]   result_q;
  logic [EXC_W-1:0]    exc_q;
  logic                eret_q;
  logic                flushed_q;
  logic [31:0]         retire_q;

  // Combinational control.
  logic in_drain_s;
  logic exc_hit_s;
  logic eret_hit_s;
  logic stall_s;
  logic ready_go_s;
  logic allowin_s;
  logic capture_s;
  logic commit_s;
  logic write_s;
  logic flush_s;
  logic retire_s;

  assign in_drain_s = (state_q == ST_DRAIN);
  assign exc_hit_s  = (|exc_q) & ~flushed_q;
  assign eret_hit_s = eret_q & ~flushed_q;
  // A write that is going to be suppressed (exception or upstream cancel) never waits on the port.
  assign stall_s    = rf_busy & (|wen_q) & ~exc_hit_s & ~flushed_q;
  assign ready_go_s = ~stall_s;
  // The drain window always accepts so MEM traffic is consumed and squashed.
  assign allowin_s  = in_drain_s | ~ws_valid_q | ready_go_s;
  assign capture_s  = ms_to_ws_valid & allowin_s;
  assign commit_s   = ws_valid_q & ready_go_s & ~in_drain_s;
  assign write_s    = commit_s & ~exc_hit_s & ~flushed_q & ~eret_q;
  assign flush_s    = commit_s & (exc_hit_s | eret_hit_s);
  assign retire_s   = commit_s & ~flushed_q & ~exc_hit_s;

  // Drain-window state machine: next state and counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (flush_s) begin
          state_d = ST_DRAIN;
          cnt_d   = DRAIN_LOAD;
        end else begin
          state_d = ST_RUN;
          cnt_d   = cnt_q;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = ST_RUN;
          cnt_d   = cnt_q;
        end else begin
          state_d = ST_DRAIN;
          cnt_d   = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Drain-window state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_RUN;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stage valid bit and payload capture; a stalled payload is held in place.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_valid_q <= 1'b0;
      pc_q       <= 32'h0000_0000;
      dest_q     <= {RF_AW{1'b0}};
      wen_q      <= {BW{1'b0}};
      result_q   <= {DATA_W{1'b0}};
      exc_q      <= {EXC_W{1'b0}};
      eret_q     <= 1'b0;
      flushed_q  <= 1'b0;
    end else begin
      if (allowin_s) begin
        ws_valid_q <= ms_to_ws_valid & ~in_drain_s;
      end
      if (capture_s) begin
        pc_q      <= ms_pc;
        dest_q    <= ms_dest;
        wen_q     <= ms_wen;
        result_q  <= ms_result;
        exc_q     <= ms_exc;
        eret_q    <= ms_eret;
        flushed_q <= ms_flushed;
      end
    end
  end

  // Retired-instruction counter; wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      retire_q <= 32'h0000_0000;
    end else if (retire_s) begin
      retire_q <= retire_q + 32'd1;
    end
  end

  assign ws_allowin = allowin_s;
  assign rf_we      = {BW{write_s}} & wen_q;
  assign rf_waddr   = ws_valid_q ? dest_q   : {RF_AW{1'b0}};
  assign rf_wdata   = ws_valid_q ? result_q : {DATA_W{1'b0}};
  assign exc_flush  = flush_s;
  assign exc_valid  = commit_s & exc_hit_s;
  assign exc_idx    = first_exc(exc_q);
  // An exception takes precedence over ERET when both are flagged.
  assign flush_pc   = exc_hit_s  ? EXC_VEC :
                      eret_hit_s ? cp0_epc : 32'h0000_0000;
  assign retire_cnt = retire_q;

  assign debug_wb_pc       = pc_q;
  assign debug_wb_rf_wen   = rf_we;
  assign debug_wb_rf_wnum  = dest_q;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage_gen.sv
// Self-checking bench for wb_stage_gen: a cycle-level reference model plus directed literal checks.
module tb_wb_stage_gen;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic [4:0]  ms_dest;
  logic [3:0]  ms_wen;
  logic [31:0] ms_result;
  logic [7:0]  ms_exc;
  logic        ms_eret;
  logic        ms_flushed;
  logic [31:0] cp0_epc;
  logic        rf_busy;
  logic [3:0]  rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        exc_flush;
  logic        exc_valid;
  logic [2:0]  exc_idx;
  logic [31:0] flush_pc;
  logic [31:0] retire_cnt;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  wb_stage_gen dut (
    .clk(clk), .resetn(resetn),
    .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_dest(ms_dest), .ms_wen(ms_wen), .ms_result(ms_result),
    .ms_exc(ms_exc), .ms_eret(ms_eret), .ms_flushed(ms_flushed),
    .cp0_epc(cp0_epc), .rf_busy(rf_busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .exc_flush(exc_flush), .exc_valid(exc_valid), .exc_idx(exc_idx),
    .flush_pc(flush_pc), .retire_cnt(retire_cnt),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the instruction sitting in WB, drain cycles left, retired count.
  logic        m_valid = 1'b0;
  logic [31:0] m_pc    = 32'h0;
  logic [4:0]  m_dest  = 5'h0;
  logic [3:0]  m_wen   = 4'h0;
  logic [31:0] m_res   = 32'h0;
  logic [7:0]  m_exc   = 8'h0;
  logic        m_eret  = 1'b0;
  logic        m_fl    = 1'b0;
  int          m_drain = 0;
  logic [31:0] m_ret   = 32'h0;

  typedef struct packed {
    logic        allowin;
    logic [3:0]  we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        flush;
    logic        excv;
    logic [2:0]  idx;
    logic [31:0] fpc;
    logic        commit;
    logic        exc_hit;
  } exp_t;

  function automatic exp_t calc();
    exp_t e;
    logic stall;
    logic draining;
    logic eret_hit;
    logic found;
    e.exc_hit = (m_exc != 8'h00) && !m_fl;
    eret_hit  = m_eret && !m_fl;
    stall     = rf_busy && (m_wen != 4'h0) && !e.exc_hit && !m_fl;
    draining  = (m_drain > 0);
    e.allowin = draining || !m_valid || !stall;
    e.commit  = m_valid && !stall && !draining;
    e.we      = (e.commit && !e.exc_hit && !m_fl && !m_eret) ? m_wen : 4'h0;
    e.waddr   = m_valid ? m_dest : 5'h0;
    e.wdata   = m_valid ? m_res : 32'h0;
    e.flush   = e.commit && (e.exc_hit || eret_hit);
    e.excv    = e.commit && e.exc_hit;
    e.idx     = 3'd0;
    found     = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!found && m_exc[i]) begin
        e.idx = 3'(i);
        found = 1'b1;
      end
    end
    e.fpc = e.exc_hit ? 32'hbfc00380 : (eret_hit ? cp0_epc : 32'h0);
    return e;
  endfunction

  // Model update on each clock edge, cleared by the asynchronous reset.
  always @(posedge clk or negedge resetn) begin
    exp_t e;
    if (!resetn) begin
      m_valid = 1'b0; m_pc = 32'h0; m_dest = 5'h0; m_wen = 4'h0; m_res = 32'h0;
      m_exc = 8'h0; m_eret = 1'b0; m_fl = 1'b0; m_drain = 0; m_ret = 32'h0;
    end else begin
      e = calc();
      if (e.commit && !m_fl && !e.exc_hit) m_ret = m_ret + 32'd1;
      if (e.allowin) begin
        if (ms_to_ws_valid) begin
          m_pc = ms_pc; m_dest = ms_dest; m_wen = ms_wen; m_res = ms_result;
          m_exc = ms_exc; m_eret = ms_eret; m_fl = ms_flushed;
        end
        m_valid = (m_drain > 0) ? 1'b0 : ms_to_ws_valid;
      end
      if (m_drain > 0) m_drain = m_drain - 1;
      else if (e.flush) m_drain = 2;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    exp_t e;
    e = calc();
    check("ws_allowin", 64'(ws_allowin), 64'(e.allowin));
    check("rf_we", 64'(rf_we), 64'(e.we));
    check("rf_waddr", 64'(rf_waddr), 64'(e.waddr));
    check("rf_wdata", 64'(rf_wdata), 64'(e.wdata));
    check("exc_flush", 64'(exc_flush), 64'(e.flush));
    check("exc_valid", 64'(exc_valid), 64'(e.excv));
    check("exc_idx", 64'(exc_idx), 64'(e.idx));
    check("flush_pc", 64'(flush_pc), 64'(e.fpc));
    check("retire_cnt", 64'(retire_cnt), 64'(m_ret));
    check("debug_wb_pc", 64'(debug_wb_pc), 64'(m_pc));
    check("debug_wb_rf_wen", 64'(debug_wb_rf_wen), 64'(e.we));
    check("debug_wb_rf_wnum", 64'(debug_wb_rf_wnum), 64'(m_dest));
    check("debug_wb_rf_wdata", 64'(debug_wb_rf_wdata), 64'(e.wdata));
  end

  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] dest,
                       input logic [3:0] wen, input logic [31:0] res, input logic [7:0] exc,
                       input logic eret, input logic fl);
    ms_to_ws_valid = v; ms_pc = pc; ms_dest = dest; ms_wen = wen;
    ms_result = res; ms_exc = exc; ms_eret = eret; ms_flushed = fl;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 5'h0, 4'h0, 32'h0, 8'h0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_allowin"}, 64'(ws_allowin), 64'd1);
    check({tag, "_rf_we"}, 64'(rf_we), 64'd0);
    check({tag, "_rf_waddr"}, 64'(rf_waddr), 64'd0);
    check({tag, "_rf_wdata"}, 64'(rf_wdata), 64'd0);
    check({tag, "_exc_flush"}, 64'(exc_flush), 64'd0);
    check({tag, "_exc_idx"}, 64'(exc_idx), 64'd0);
    check({tag, "_flush_pc"}, 64'(flush_pc), 64'd0);
    check({tag, "_retire"}, 64'(retire_cnt), 64'd0);
    check({tag, "_dbg_pc"}, 64'(debug_wb_pc), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0; rf_busy = 1'b0; cp0_epc = 32'h0;
    idle();
    #2;
    check_all_zero("reset");
    tick();
    resetn = 1'b1;

    // Write with no stall.
    drive(1'b1, 32'hbfc00000, 5'd5, 4'hF, 32'h12345678, 8'h00, 1'b0, 1'b0);
    tick(); idle();
    @(negedge clk);
    check("w_rf_we", 64'(rf_we), 64'hF);
    check("w_rf_waddr", 64'(rf_waddr), 64'd5);
    check("w_rf_wdata", 64'(rf_wdata), 64'h12345678);
    tick();
    @(negedge clk);
    check("w_retire", 64'(retire_cnt), 64'd1);

    // Register-file port contention for three cycles; next instruction waits in MEM.
    drive(1'b1, 32'hbfc00004, 5'd7, 4'b0011, 32'ha5a50003, 8'h00, 1'b0, 1'b0);
    rf_busy = 1'b1;
    tick();
    drive(1'b1, 32'hbfc00008, 5'd9, 4'hF, 32'h00000099, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("s_rf_we", 64'(rf_we), 64'd0);
      check("s_allowin", 64'(ws_allowin), 64'd0);
      check("s_hold_pc", 64'(debug_wb_pc), 64'hbfc00004);
      tick();
    end
    rf_busy = 1'b0;
    @(negedge clk);
    check("s_rf_we_rel", 64'(rf_we), 64'b0011);
    check("s_rf_waddr", 64'(rf_waddr), 64'd7);
    tick(); idle();
    @(negedge clk);
    check("s_next_we", 64'(rf_we), 64'hF);
    check("s_next_waddr", 64'(rf_waddr), 64'd9);
    tick();
    @(negedge clk);
    check("s_retire", 64'(retire_cnt), 64'd3);

    // Exception, then drain window.
    drive(1'b1, 32'hbfc0000c, 5'd3, 4'hF, 32'h33333333, 8'b0010_0100, 1'b0, 1'b0);
    tick(); idle();
    @(negedge clk);
    check("e_flush", 64'(exc_flush), 64'd1);
    check("e_valid", 64'(exc_valid), 64'd1);
    check("e_idx", 64'(exc_idx), 64'd2);
    check("e_flush_pc", 64'(flush_pc), 64'hbfc00380);
    check("e_rf_we", 64'(rf_we), 64'd0);
    tick();
    drive(1'b1, 32'hbfc00100, 5'd10, 4'hF, 32'h0000000a, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    check("d1_rf_we", 64'(rf_we), 64'd0);
    check("d1_allowin", 64'(ws_allowin), 64'd1);
    tick();
    drive(1'b1, 32'hbfc00104, 5'd11, 4'hF, 32'h0000000b, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    check("d2_rf_we", 64'(rf_we), 64'd0);
    tick();
    drive(1'b1, 32'hbfc00108, 5'd12, 4'hF, 32'h0000000c, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    check("d3_rf_we", 64'(rf_we), 64'd0);
    check("d3_flush", 64'(exc_flush), 64'd0);
    tick(); idle();
    @(negedge clk);
    check("d4_rf_we", 64'(rf_we), 64'hF);
    check("d4_waddr", 64'(rf_waddr), 64'd12);
    tick();
    @(negedge clk);
    check("d_retire", 64'(retire_cnt), 64'd4);

    // ERET redirects to EPC and counts as retired.
    cp0_epc = 32'h80001234;
    drive(1'b1, 32'hbfc00010, 5'd0, 4'h0, 32'h0, 8'h00, 1'b1, 1'b0);
    tick(); idle();
    @(negedge clk);
    check("r_flush", 64'(exc_flush), 64'd1);
    check("r_valid", 64'(exc_valid), 64'd0);
    check("r_flush_pc", 64'(flush_pc), 64'h80001234);
    check("r_rf_we", 64'(rf_we), 64'd0);
    tick();
    @(negedge clk);
    check("r_retire", 64'(retire_cnt), 64'd5);
    tick(); tick(); tick();

    // Upstream-cancelled instruction: nothing happens, no stall.
    rf_busy = 1'b1;
    drive(1'b1, 32'hbfc00014, 5'd4, 4'hF, 32'h44444444, 8'h01, 1'b0, 1'b1);
    tick(); idle();
    @(negedge clk);
    check("f_rf_we", 64'(rf_we), 64'd0);
    check("f_flush", 64'(exc_flush), 64'd0);
    check("f_allowin", 64'(ws_allowin), 64'd1);
    check("f_flush_pc", 64'(flush_pc), 64'd0);
    tick();
    rf_busy = 1'b0;
    @(negedge clk);
    check("f_retire", 64'(retire_cnt), 64'd5);

    // Reset while draining after an exception on the lowest-priority source.
    drive(1'b1, 32'hbfc00018, 5'd6, 4'hF, 32'h66666666, 8'h80, 1'b0, 1'b0);
    tick(); idle();
    @(negedge clk);
    check("x_flush", 64'(exc_flush), 64'd1);
    check("x_idx", 64'(exc_idx), 64'd7);
    tick();
    resetn = 1'b0;
    #2;
    check_all_zero("rst_drain");
    @(negedge clk);
    tick();
    resetn = 1'b1;
    drive(1'b1, 32'hbfc00020, 5'd1, 4'hF, 32'h0000cafe, 8'h00, 1'b0, 1'b0);
    tick(); idle();
    @(negedge clk);
    check("y_rf_we", 64'(rf_we), 64'hF);
    check("y_rf_wdata", 64'(rf_wdata), 64'h0000cafe);
    tick();
    @(negedge clk);
    check("y_retire", 64'(retire_cnt), 64'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
